// File: rtl/dmem_line_buffer_pkg.sv
// Shared types and helpers for the dmem line buffer: line, tag and byte-mask
// types, FSM state encoding, and the store-lane helpers.
package dmem_line_buffer_pkg;

    localparam int unsigned LINE_W = 128;
    localparam int unsigned TAG_W  = 12;
    localparam int unsigned MASK_W = 16;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned WORDS  = LINE_W / WORD_W;

    typedef logic [LINE_W-1:0] lc3b_line;
    typedef logic [TAG_W-1:0]  lc3b_line_tag;
    typedef logic [MASK_W-1:0] lc3b_line_mask;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        RESP
    } dmem_lb_state_t;

    // Store data is already lane-aligned upstream, so every word lane carries it.
    function automatic lc3b_line replicate_word(input logic [WORD_W-1:0] word);
        return {WORDS{word}};
    endfunction

    function automatic lc3b_line_mask word_mask(input logic [2:0] word_idx,
                                                input logic [1:0] byte_en);
        lc3b_line_mask mask;
        mask = '0;
        mask[{word_idx, 1'b0} +: 2] = byte_en;
        return mask;
    endfunction

endpackage

// File: rtl/dmem_line_buffer_line_merge.sv
// Combinational byte-wise merge of replicated store data into a 128-bit line.
module line_merge
    import dmem_line_buffer_pkg::*;
(
    input  lc3b_line      line_in,
    input  lc3b_line      data,
    input  lc3b_line_mask sel,
    output lc3b_line      merged
);

    always_comb begin
        merged = line_in;
        for (int unsigned b = 0; b < MASK_W; b++) begin
            if (sel[b]) begin
                merged[b*8 +: 8] = data[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_line_buffer.sv
// Single-line read buffer with write-through stores between the memory stage
// and the line-wide data bus. Define DMEM_LB_STATS_EN to add hit/miss counters.
module dmem_line_buffer
    import dmem_line_buffer_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dmem_action_stb,
    input  logic               dmem_action_cyc,
    input  logic               dmem_write,
    input  logic [ADDR_W-1:0]  dmem_address,
    input  logic [WORD_W-1:0]  dmem_wdata,
    input  logic [1:0]         dmem_byte_enable,
    input  logic               flush,
    output lc3b_line           dmem_rdata,
    output logic               dmem_resp,
    output logic               dmem_err,
    output logic               wb_cyc,
    output logic               wb_stb,
    output logic               wb_we,
    output lc3b_line_tag       wb_adr,
    output lc3b_line           wb_dat_o,
    output lc3b_line_mask      wb_sel,
    input  lc3b_line           wb_dat_i,
    input  logic               wb_ack
`ifdef DMEM_LB_STATS_EN
    ,
    output logic [15:0]        hit_count,
    output logic [15:0]        miss_count
`endif
);

    localparam int unsigned CNT_W      = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int unsigned CNT_LAST   = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;
    localparam bit          TIMEOUT_EN = (ACK_TIMEOUT != 0);

    dmem_lb_state_t state, state_nxt;
    logic           valid, valid_nxt;
    lc3b_line_tag   tag, tag_nxt;
    lc3b_line       line, line_nxt;
    logic           flush_pend, flush_pend_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;

    lc3b_line       rdata_nxt, dat_nxt;
    lc3b_line_tag   adr_nxt;
    lc3b_line_mask  sel_nxt;
    logic           resp_nxt, err_nxt, cyc_nxt, stb_nxt, we_nxt;

    logic           req_c, hit_c, timed_out_c, store_hit_c;
    lc3b_line       merged_c;
    logic           unused_addr_bit;

    assign req_c           = dmem_action_stb & dmem_action_cyc;
    assign hit_c           = valid & ~flush & ~flush_pend & (tag == dmem_address[15:4]);
    assign timed_out_c     = TIMEOUT_EN && (wait_cnt == CNT_W'(CNT_LAST));
    assign store_hit_c     = valid & (tag == wb_adr);
    assign unused_addr_bit = dmem_address[0];

    line_merge u_line_merge (
        .line_in (line),
        .data    (wb_dat_o),
        .sel     (wb_sel),
        .merged  (merged_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt      = state;
        valid_nxt      = valid;
        tag_nxt        = tag;
        line_nxt       = line;
        flush_pend_nxt = flush_pend;
        wait_cnt_nxt   = wait_cnt;
        cyc_nxt        = wb_cyc;
        stb_nxt        = wb_stb;
        we_nxt         = wb_we;
        adr_nxt        = wb_adr;
        sel_nxt        = wb_sel;
        dat_nxt        = wb_dat_o;
        rdata_nxt      = dmem_rdata;
        resp_nxt       = 1'b0;
        err_nxt        = 1'b0;

        // A flush arriving while busy is held until the buffer is quiet again.
        if (flush && (state != IDLE)) begin
            flush_pend_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                if (flush || flush_pend) begin
                    valid_nxt      = 1'b0;
                    flush_pend_nxt = 1'b0;
                end
                if (req_c) begin
                    adr_nxt      = dmem_address[15:4];
                    sel_nxt      = word_mask(dmem_address[3:1], dmem_byte_enable);
                    dat_nxt      = replicate_word(dmem_wdata);
                    wait_cnt_nxt = '0;
                    if (dmem_write) begin
                        state_nxt = WRITE;
                        cyc_nxt   = 1'b1;
                        stb_nxt   = 1'b1;
                        we_nxt    = 1'b1;
                    end else if (hit_c) begin
                        state_nxt = RESP;
                        resp_nxt  = 1'b1;
                        rdata_nxt = line;
                    end else begin
                        state_nxt = FILL;
                        cyc_nxt   = 1'b1;
                        stb_nxt   = 1'b1;
                        we_nxt    = 1'b0;
                    end
                end
            end
            FILL: begin
                if (wb_ack) begin
                    line_nxt       = wb_dat_i;
                    tag_nxt        = wb_adr;
                    valid_nxt      = ~(flush_pend | flush);
                    flush_pend_nxt = 1'b0;
                    rdata_nxt      = wb_dat_i;
                end else if (timed_out_c) begin
                    valid_nxt      = 1'b0;
                    rdata_nxt      = '0;
                    err_nxt        = 1'b1;
                end else begin
                    wait_cnt_nxt   = wait_cnt + 1'b1;
                end
                if (wb_ack || timed_out_c) begin
                    state_nxt = RESP;
                    resp_nxt  = 1'b1;
                    cyc_nxt   = 1'b0;
                    stb_nxt   = 1'b0;
                    we_nxt    = 1'b0;
                end
            end
            WRITE: begin
                if (wb_ack) begin
                    if (store_hit_c) begin
                        line_nxt  = merged_c;
                        rdata_nxt = merged_c;
                    end else begin
                        rdata_nxt = '0;
                    end
                end else if (timed_out_c) begin
                    rdata_nxt = '0;
                    err_nxt   = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
                if (wb_ack || timed_out_c) begin
                    state_nxt = RESP;
                    resp_nxt  = 1'b1;
                    cyc_nxt   = 1'b0;
                    stb_nxt   = 1'b0;
                    we_nxt    = 1'b0;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            valid      <= 1'b0;
            tag        <= '0;
            line       <= '0;
            flush_pend <= 1'b0;
            wait_cnt   <= '0;
            wb_cyc     <= 1'b0;
            wb_stb     <= 1'b0;
            wb_we      <= 1'b0;
            wb_adr     <= '0;
            wb_sel     <= '0;
            wb_dat_o   <= '0;
            dmem_rdata <= '0;
            dmem_resp  <= 1'b0;
            dmem_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            valid      <= valid_nxt;
            tag        <= tag_nxt;
            line       <= line_nxt;
            flush_pend <= flush_pend_nxt;
            wait_cnt   <= wait_cnt_nxt;
            wb_cyc     <= cyc_nxt;
            wb_stb     <= stb_nxt;
            wb_we      <= we_nxt;
            wb_adr     <= adr_nxt;
            wb_sel     <= sel_nxt;
            wb_dat_o   <= dat_nxt;
            dmem_rdata <= rdata_nxt;
            dmem_resp  <= resp_nxt;
            dmem_err   <= err_nxt;
        end
    end

`ifdef DMEM_LB_STATS_EN
    logic load_req_c;
    assign load_req_c = (state == IDLE) & req_c & ~dmem_write;

    // Saturating load hit/miss counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (load_req_c) begin
            if (hit_c && (hit_count != 16'hFFFF)) begin
                hit_count <= hit_count + 16'd1;
            end else if (!hit_c && (miss_count != 16'hFFFF)) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_line_buffer.sv
// Directed self-checking bench for dmem_line_buffer (ACK_TIMEOUT = 4).
module tb_dmem_line_buffer;

    localparam logic [127:0] LINE_A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_AAAA;
    localparam logic [127:0] MERGED = 128'h0123_4567_89AB_CDEF_55DC_BA98_7654_AAAA;
    localparam logic [127:0] LINE_B = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    localparam logic [127:0] DAT55  = {8{16'h5500}};

    logic         clk = 1'b0;
    logic         rst;
    logic         dmem_action_stb, dmem_action_cyc, dmem_write, flush;
    logic [15:0]  dmem_address, dmem_wdata;
    logic [1:0]   dmem_byte_enable;
    logic [127:0] dmem_rdata, wb_dat_o, wb_dat_i;
    logic         dmem_resp, dmem_err, wb_cyc, wb_stb, wb_we, wb_ack;
    logic [11:0]  wb_adr;
    logic [15:0]  wb_sel;
`ifdef DMEM_LB_STATS_EN
    logic [15:0]  hit_count, miss_count;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_line_buffer #(.ACK_TIMEOUT(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .dmem_action_stb  (dmem_action_stb),
        .dmem_action_cyc  (dmem_action_cyc),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .flush            (flush),
        .dmem_rdata       (dmem_rdata),
        .dmem_resp        (dmem_resp),
        .dmem_err         (dmem_err),
        .wb_cyc           (wb_cyc),
        .wb_stb           (wb_stb),
        .wb_we            (wb_we),
        .wb_adr           (wb_adr),
        .wb_dat_o         (wb_dat_o),
        .wb_sel           (wb_sel),
        .wb_dat_i         (wb_dat_i),
        .wb_ack           (wb_ack)
`ifdef DMEM_LB_STATS_EN
        ,
        .hit_count        (hit_count),
        .miss_count       (miss_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic wr, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [1:0] be);
        dmem_action_stb  = 1'b1;
        dmem_action_cyc  = 1'b1;
        dmem_write       = wr;
        dmem_address     = addr;
        dmem_wdata       = wdata;
        dmem_byte_enable = be;
    endtask

    task automatic req_off();
        dmem_action_stb = 1'b0;
        dmem_action_cyc = 1'b0;
    endtask

    task automatic ack(input logic [127:0] data);
        wb_ack   = 1'b1;
        wb_dat_i = data;
        tick();
        wb_ack   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (wb_cyc !== 1'b0) begin failures++; $display("FAIL reset_cyc got=%0h exp=0", wb_cyc); end
        checks++; if (wb_stb !== 1'b0) begin failures++; $display("FAIL reset_stb got=%0h exp=0", wb_stb); end
        checks++; if (wb_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%0h exp=0", wb_we); end
        checks++; if (dmem_resp !== 1'b0) begin failures++; $display("FAIL reset_resp got=%0h exp=0", dmem_resp); end
        checks++; if (dmem_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0h exp=0", dmem_err); end
        checks++; if (wb_adr !== 12'h0) begin failures++; $display("FAIL reset_adr got=%h exp=0", wb_adr); end
        checks++; if (wb_sel !== 16'h0) begin failures++; $display("FAIL reset_sel got=%h exp=0", wb_sel); end
        checks++; if (wb_dat_o !== 128'h0) begin failures++; $display("FAIL reset_dat_o got=%h exp=0", wb_dat_o); end
        checks++; if (dmem_rdata !== 128'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", dmem_rdata); end
        rst = 1'b0;
    endtask

    task automatic test_load_miss();
        req(1'b0, 16'h1234, 16'h0, 2'b11);
        tick();
        checks++; if (wb_cyc !== 1'b1 || wb_stb !== 1'b1) begin failures++; $display("FAIL miss_cyc_stb got=%0h%0h exp=11", wb_cyc, wb_stb); end
        checks++; if (wb_we !== 1'b0) begin failures++; $display("FAIL miss_we got=%0h exp=0", wb_we); end
        checks++; if (wb_adr !== 12'h123) begin failures++; $display("FAIL miss_adr got=%h exp=123", wb_adr); end
        checks++; if (dmem_resp !== 1'b0) begin failures++; $display("FAIL miss_early_resp got=%0h exp=0", dmem_resp); end
        tick();
        ack(LINE_A);
        checks++; if (dmem_resp !== 1'b1) begin failures++; $display("FAIL miss_resp got=%0h exp=1", dmem_resp); end
        checks++; if (dmem_rdata !== LINE_A) begin failures++; $display("FAIL miss_rdata got=%h exp=%h", dmem_rdata, LINE_A); end
        checks++; if (wb_cyc !== 1'b0 || dmem_err !== 1'b0) begin failures++; $display("FAIL miss_drop got=%0h%0h exp=00", wb_cyc, dmem_err); end
        req_off();
        tick();
        checks++; if (dmem_resp !== 1'b0) begin failures++; $display("FAIL miss_resp_pulse got=%0h exp=0", dmem_resp); end
    endtask

    task automatic test_load_hit();
        req(1'b0, 16'h123A, 16'h0, 2'b11);
        tick();
        checks++; if (dmem_resp !== 1'b1) begin failures++; $display("FAIL hit_resp got=%0h exp=1", dmem_resp); end
        checks++; if (dmem_rdata !== LINE_A) begin failures++; $display("FAIL hit_rdata got=%h exp=%h", dmem_rdata, LINE_A); end
        checks++; if (wb_cyc !== 1'b0) begin failures++; $display("FAIL hit_no_bus got=%0h exp=0", wb_cyc); end
        req_off();
        tick();
        checks++; if (dmem_resp !== 1'b0) begin failures++; $display("FAIL hit_resp_pulse got=%0h exp=0", dmem_resp); end
    endtask

    task automatic test_store_hit();
        req(1'b1, 16'h1236, 16'h5500, 2'b10);
        tick();
        checks++; if (wb_cyc !== 1'b1 || wb_we !== 1'b1) begin failures++; $display("FAIL st_cyc_we got=%0h%0h exp=11", wb_cyc, wb_we); end
        checks++; if (wb_sel !== 16'h0080) begin failures++; $display("FAIL st_sel got=%h exp=0080", wb_sel); end
        checks++; if (wb_dat_o !== DAT55) begin failures++; $display("FAIL st_dat_o got=%h exp=%h", wb_dat_o, DAT55); end
        checks++; if (wb_adr !== 12'h123) begin failures++; $display("FAIL st_adr got=%h exp=123", wb_adr); end
        ack(128'h0);
        checks++; if (dmem_resp !== 1'b1) begin failures++; $display("FAIL st_resp got=%0h exp=1", dmem_resp); end
        checks++; if (dmem_rdata !== MERGED) begin failures++; $display("FAIL st_rdata got=%h exp=%h", dmem_rdata, MERGED); end
        req_off();
        tick();
        req(1'b0, 16'h1234, 16'h0, 2'b11);
        tick();
        checks++; if (dmem_resp !== 1'b1 || wb_cyc !== 1'b0) begin failures++; $display("FAIL st_rehit got=%0h%0h exp=10", dmem_resp, wb_cyc); end
        checks++; if (dmem_rdata !== MERGED) begin failures++; $display("FAIL st_rehit_rdata got=%h exp=%h", dmem_rdata, MERGED); end
        req_off();
        tick();
    endtask

    task automatic test_store_miss();
        req(1'b1, 16'h2000, 16'hBEEF, 2'b11);
        tick();
        checks++; if (wb_we !== 1'b1 || wb_cyc !== 1'b1) begin failures++; $display("FAIL sm_we_cyc got=%0h%0h exp=11", wb_we, wb_cyc); end
        checks++; if (wb_adr !== 12'h200) begin failures++; $display("FAIL sm_adr got=%h exp=200", wb_adr); end
        checks++; if (wb_sel !== 16'h0003) begin failures++; $display("FAIL sm_sel got=%h exp=0003", wb_sel); end
        ack(128'h0);
        checks++; if (dmem_resp !== 1'b1) begin failures++; $display("FAIL sm_resp got=%0h exp=1", dmem_resp); end
        checks++; if (dmem_rdata !== 128'h0) begin failures++; $display("FAIL sm_rdata got=%h exp=0", dmem_rdata); end
        req_off();
        tick();
        req(1'b0, 16'h1234, 16'h0, 2'b11);
        tick();
        checks++; if (dmem_resp !== 1'b1 || wb_cyc !== 1'b0) begin failures++; $display("FAIL sm_still_hit got=%0h%0h exp=10", dmem_resp, wb_cyc); end
        checks++; if (dmem_rdata !== MERGED) begin failures++; $display("FAIL sm_unchanged got=%h exp=%h", dmem_rdata, MERGED); end
        req_off();
        tick();
    endtask

    task automatic test_back_to_back();
        req(1'b0, 16'h1230, 16'h0, 2'b11);
        tick();
        checks++; if (dmem_resp !== 1'b1) begin failures++; $display("FAIL b2b_first got=%0h exp=1", dmem_resp); end
        tick();
        checks++; if (dmem_resp !== 1'b0) begin failures++; $display("FAIL b2b_gap got=%0h exp=0", dmem_resp); end
        tick();
        checks++; if (dmem_resp !== 1'b1) begin failures++; $display("FAIL b2b_second got=%0h exp=1", dmem_resp); end
        req_off();
        tick();
    endtask

    task automatic test_timeout();
        req(1'b0, 16'h4560, 16'h0, 2'b11);
        tick();
        checks++; if (wb_cyc !== 1'b1) begin failures++; $display("FAIL to_start got=%0h exp=1", wb_cyc); end
        repeat (3) tick();
        checks++; if (wb_cyc !== 1'b1 || dmem_resp !== 1'b0) begin failures++; $display("FAIL to_still_wait got=%0h%0h exp=10", wb_cyc, dmem_resp); end
        tick();
        checks++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin failures++; $display("FAIL to_drop got=%0h%0h exp=00", wb_cyc, wb_stb); end
        checks++; if (dmem_resp !== 1'b1 || dmem_err !== 1'b1) begin failures++; $display("FAIL to_err got=%0h%0h exp=11", dmem_resp, dmem_err); end
        req_off();
        tick();
        checks++; if (dmem_err !== 1'b0) begin failures++; $display("FAIL to_err_pulse got=%0h exp=0", dmem_err); end
        req(1'b0, 16'h1234, 16'h0, 2'b11);
        tick();
        checks++; if (wb_cyc !== 1'b1) begin failures++; $display("FAIL to_invalidated got=%0h exp=1", wb_cyc); end
        ack(LINE_A);
        checks++; if (dmem_rdata !== LINE_A) begin failures++; $display("FAIL to_refill got=%h exp=%h", dmem_rdata, LINE_A); end
        req_off();
        tick();
        req(1'b1, 16'h1234, 16'hFFFF, 2'b11);
        tick();
        repeat (4) tick();
        checks++; if (dmem_err !== 1'b1 || wb_cyc !== 1'b0) begin failures++; $display("FAIL to_store got=%0h%0h exp=10", dmem_err, wb_cyc); end
        req_off();
        tick();
        req(1'b0, 16'h1234, 16'h0, 2'b11);
        tick();
        checks++; if (dmem_resp !== 1'b1 || dmem_rdata !== LINE_A) begin failures++; $display("FAIL to_store_keeps got=%0h %h exp=1 %h", dmem_resp, dmem_rdata, LINE_A); end
        req_off();
        tick();
    endtask

    task automatic test_reset_mid_fill();
        req(1'b0, 16'h7770, 16'h0, 2'b11);
        tick();
        checks++; if (wb_cyc !== 1'b1) begin failures++; $display("FAIL rmf_fill got=%0h exp=1", wb_cyc); end
        rst      = 1'b1;
        wb_ack   = 1'b1;
        wb_dat_i = LINE_B;
        tick();
        checks++; if ({wb_cyc, wb_stb, wb_we, dmem_resp, dmem_err} !== 5'b0) begin failures++; $display("FAIL rmf_ctrl got=%b exp=00000", {wb_cyc, wb_stb, wb_we, dmem_resp, dmem_err}); end
        checks++; if (wb_adr !== 12'h0 || wb_sel !== 16'h0) begin failures++; $display("FAIL rmf_adr_sel got=%h %h exp=0 0", wb_adr, wb_sel); end
        checks++; if (wb_dat_o !== 128'h0 || dmem_rdata !== 128'h0) begin failures++; $display("FAIL rmf_data got=%h %h exp=0 0", wb_dat_o, dmem_rdata); end
        rst    = 1'b0;
        wb_ack = 1'b0;
        req_off();
        tick();
        checks++; if (dmem_resp !== 1'b0) begin failures++; $display("FAIL rmf_ack_ignored got=%0h exp=0", dmem_resp); end
        req(1'b0, 16'h1234, 16'h0, 2'b11);
        tick();
        checks++; if (wb_cyc !== 1'b1) begin failures++; $display("FAIL rmf_valid_clr got=%0h exp=1", wb_cyc); end
        ack(LINE_A);
        req_off();
        tick();
    endtask

    task automatic test_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        req(1'b0, 16'h1234, 16'h0, 2'b11);
        tick();
        checks++; if (wb_cyc !== 1'b1) begin failures++; $display("FAIL fl_idle got=%0h exp=1", wb_cyc); end
        ack(LINE_A);
        req_off();
        tick();
        flush = 1'b1;
        req(1'b0, 16'h1234, 16'h0, 2'b11);
        tick();
        flush = 1'b0;
        checks++; if (wb_cyc !== 1'b1 || dmem_resp !== 1'b0) begin failures++; $display("FAIL fl_same_cycle got=%0h%0h exp=10", wb_cyc, dmem_resp); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ack(LINE_A);
        checks++; if (dmem_resp !== 1'b1 || dmem_rdata !== LINE_A) begin failures++; $display("FAIL fl_fill_data got=%0h %h exp=1 %h", dmem_resp, dmem_rdata, LINE_A); end
        req_off();
        tick();
        req(1'b0, 16'h1234, 16'h0, 2'b11);
        tick();
        checks++; if (wb_cyc !== 1'b1) begin failures++; $display("FAIL fl_during_fill got=%0h exp=1", wb_cyc); end
        ack(LINE_A);
        req_off();
        tick();
        req(1'b0, 16'h1234, 16'h0, 2'b11);
        tick();
        checks++; if (dmem_resp !== 1'b1 || wb_cyc !== 1'b0) begin failures++; $display("FAIL fl_rehit got=%0h%0h exp=10", dmem_resp, wb_cyc); end
        req_off();
        tick();
    endtask

    initial begin
        rst              = 1'b1;
        dmem_action_stb  = 1'b0;
        dmem_action_cyc  = 1'b0;
        dmem_write       = 1'b0;
        dmem_address     = 16'h0;
        dmem_wdata       = 16'h0;
        dmem_byte_enable = 2'b00;
        flush            = 1'b0;
        wb_dat_i         = 128'h0;
        wb_ack           = 1'b0;

        test_reset();
        test_load_miss();
        test_load_hit();
        test_store_hit();
        test_store_miss();
        test_back_to_back();
        test_timeout();
        test_reset_mid_fill();
        test_flush();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_line_buffer.md
Name: dmem_line_buffer

Overview:
- Sits directly downstream of the pipeline's memory stage, between its word-level dmem request port and the line-wide Wishbone-style data memory bus.
- Holds one 128-bit line (tag plus valid bit) so repeated loads to the same line return in one cycle.
- Misses trigger a line fill. Stores are write-through with a byte-merge into the buffered line on a tag match.
- Returns the full 128-bit line to the memory stage, which selects the word by address bits [3:1].

Parameters:
- ACK_TIMEOUT, 255: maximum cycles to wait for wb_ack before abandoning a bus cycle. 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- dmem_action_stb  in  1  upstream request strobe
- dmem_action_cyc  in  1  upstream cycle valid; a request requires stb and cyc both high
- dmem_write  in  1  1 = store, 0 = load
- dmem_address  in  16  byte address
- dmem_wdata  in  16  store word, already byte-aligned by upstream
- dmem_byte_enable  in  2  byte lanes of the addressed word
- flush  in  1  invalidate the buffered line
- dmem_rdata  out  128  line data, valid while dmem_resp=1
- dmem_resp  out  1  one-cycle completion pulse
- dmem_err  out  1  high with dmem_resp when the access timed out
- wb_cyc  out  1  bus cycle
- wb_stb  out  1  bus strobe
- wb_we  out  1  bus write enable
- wb_adr  out  12  line address, equal to dmem_address[15:4]
- wb_dat_o  out  128  write data: dmem_wdata replicated into all 8 word lanes
- wb_sel  out  16  byte selects: dmem_byte_enable placed at bits [2*a+1:2*a], a = dmem_address[3:1]; all other bits 0
- wb_dat_i  in  128  bus read data
- wb_ack  in  1  bus acknowledge

Behaviour:
- Reset (synchronous, active-high). Takes effect at the next clk edge, including mid-operation. Required values:
  - state = IDLE, valid = 0
  - wb_cyc, wb_stb, wb_we, dmem_resp, dmem_err = 0
  - wb_adr, wb_sel, wb_dat_o, dmem_rdata = 0
  - An ack arriving in the reset cycle is ignored.
- FSM states are IDLE, FILL, WRITE, RESP. All outputs are registered.
- IDLE, request sampled:
  - Load with valid and tag == address[15:4] (hit) -> RESP; dmem_rdata <= line.
  - Load miss -> FILL; wb_cyc = wb_stb = 1, wb_we = 0.
  - Store -> WRITE; wb_cyc = wb_stb = wb_we = 1; wb_sel and wb_dat_o as defined under Ports.
- FILL, on wb_ack:
  - line <= wb_dat_i, tag <= address[15:4], valid <= 1.
  - Drop wb_cyc/wb_stb; dmem_rdata <= wb_dat_i; go to RESP.
- WRITE, on wb_ack:
  - On a tag hit with valid set, merge wdata bytes into line under wb_sel; otherwise the buffer is unchanged (no write-allocate).
  - Drop the bus; dmem_rdata <= updated line, or 0 on a miss; go to RESP.
- Timeout: a wait counter resets on entry to FILL or WRITE.
  - When it reaches ACK_TIMEOUT: drop the bus, set dmem_err = 1, go to RESP.
  - valid is cleared on a FILL timeout only.
- RESP:
  - dmem_resp = 1 for exactly one cycle, then return to IDLE.
  - Requests seen during RESP are ignored; upstream deasserts stb/cyc or keeps them held into IDLE, where they count as a new request.
- Latency: load hit responds 1 cycle after the request is sampled; miss or store responds 1 cycle after wb_ack.
- Upstream holds address, data and control stable until dmem_resp. The block does not re-sample mid-access.
- flush:
  - In IDLE, clears valid at the next edge. A request in the same cycle is treated as a miss.
  - In FILL, flush is latched and applied after the fill, so the new line is installed then invalidated.
- Stores always write through to the bus, whether they hit or miss.

Optional Feature:
DMEM_LB_STATS_EN:
- Defined: adds outputs hit_count[15:0] and miss_count[15:0]. Each counts load hits or load misses, saturates at 16'hFFFF, and is cleared by rst.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- lc3b_types gains:
  - lc3b_line (128-bit)
  - lc3b_line_tag (12-bit)
  - lc3b_line_mask (16-bit)
  - enum dmem_lb_state_t
- Sub-module line_merge: combinational byte-wise merge of the line, replicated data and the 16-bit select.

Test Plan:
- Load 0x1234 after reset -> FILL, wb_adr = 0x123; ack with line 0x…AAAA -> dmem_resp 1 cycle later with that line; valid set.
- Second load 0x123A -> dmem_resp exactly 1 cycle after the request; no wb_cyc.
- Store 0x1236, byte_enable 2'b10, wdata 0x5500 -> wb_sel = 16'h0080; on ack, line byte 7 = 0x55; a following load hit returns the merged line.
- Store to 0x2000 (miss) -> bus write issued; buffer unchanged; load 0x1234 still hits.
- Withhold wb_ack with ACK_TIMEOUT = 4 -> bus dropped after 4 cycles; dmem_resp with dmem_err = 1; next load to the same line misses.
- Assert rst mid-FILL, then ack -> all outputs 0, valid 0, ack ignored; flush in IDLE then load 0x1234 -> miss.
